// File: rtl/keypad_char_fifo_pkg.sv
// Shared keypad definitions: FSM state encoding, ASCII constants and the
// raw active-low keypad code to ASCII mapping.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [6:0] ASCII_DIGIT0   = 7'h30;
    localparam logic [6:0] ASCII_LETTER_A = 7'h41;
    localparam logic [6:0] ASCII_STAR     = 7'h2A;
    localparam logic [6:0] ASCII_HASH     = 7'h23;

    // Codes run downward: 4'hF is '0', 4'h6 is '9', 4'h5 is 'A', 4'h2 is 'D'.
    function automatic logic [6:0] key_to_ascii(input logic [3:0] code);
        logic [6:0] ch;
        if (code >= 4'h6) begin
            ch = ASCII_DIGIT0 + 7'(4'hF - code);
        end else if (code >= 4'h2) begin
            ch = ASCII_LETTER_A + 7'(4'h5 - code);
        end else if (code == 4'h1) begin
            ch = ASCII_STAR;
        end else begin
            ch = ASCII_HASH;
        end
        return ch;
    endfunction

endpackage

// File: rtl/keypad_char_fifo_if.sv
// Character stream handshake between the keypad FIFO and its consumer.
interface keypad_char_fifo_if #(
    parameter int CHAR_W = 8
);
    logic [CHAR_W-1:0] char_data;
    logic              char_valid;
    logic              char_ready;

    modport master (output char_data, output char_valid, input char_ready);
    modport slave  (input char_data, input char_valid, output char_ready);
endinterface

// File: rtl/keypad_char_fifo_sync_fifo.sv
// Single-clock FIFO with registered head output, occupancy count and flush.
// The head register is loaded from the entry that will be at the front next cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             push;
    logic             pop;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == FULL_COUNT);
    assign pop         = rd_en && !empty && !flush;
    assign push        = wr_en && (!full || pop) && !flush;
    assign rd_ptr_next = rd_ptr_reg + AW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(push);
            rd_ptr_reg <= rd_ptr_next;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // The array write lands after this read, so a write to the next head slot is forwarded.
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                rd_data_reg <= wr_data;
            end else begin
                rd_data_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = !empty;
    assign count    = count_reg;

endmodule

// File: rtl/keypad_char_fifo.sv
// Keypad front end: debounces press and release, emits one ASCII character per
// press into a FIFO and reports dropped characters through a sticky flag.
module keypad_char_fifo
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DEPTH           = 8,
    parameter int CHAR_W          = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               key_code,
    input  logic                     key_pressed,
    input  logic                     flush,
    keypad_char_fifo_if.master       chars,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic                     overflow
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    kp_state_e         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [3:0]        code_reg, code_next;
    logic              armed_reg, armed_next;
    logic              push_reg, push_next;
    logic [CHAR_W-1:0] char_reg, char_next;
    logic              overflow_reg;
    logic              fifo_full;
    logic              fifo_empty;

    // armed_reg blocks a key that was already down when reset released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            code_reg  <= '0;
            armed_reg <= 1'b0;
            push_reg  <= 1'b0;
            char_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            code_reg  <= code_next;
            armed_reg <= armed_next;
            push_reg  <= push_next;
            char_reg  <= char_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        code_next  = code_reg;
        armed_next = armed_reg;
        case (state_reg)
            ST_IDLE: begin
                armed_next = armed_reg | ~key_pressed;
                if (key_pressed && armed_reg) begin
                    state_next = ST_DEBOUNCE;
                    code_next  = key_code;
                    cnt_next   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!key_pressed || (key_code != code_reg)) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = ST_HELD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!key_pressed) begin
                    state_next = ST_RELEASE;
                    cnt_next   = '0;
                end
            end
            ST_RELEASE: begin
                if (key_pressed) begin
                    state_next = ST_HELD;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        push_next = (state_reg == ST_DEBOUNCE) && key_pressed &&
                    (key_code == code_reg) && (cnt_reg == CNT_MAX);
        char_next = CHAR_W'(key_to_ascii(code_reg));
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overflow_reg <= 1'b0;
        end else if (push_reg && fifo_full && !chars.char_ready) begin
            overflow_reg <= 1'b1;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en    (push_reg),
        .wr_data  (char_reg),
        .rd_en    (chars.char_ready),
        .rd_data  (chars.char_data),
        .rd_valid (chars.char_valid),
        .count    (fill_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign overflow = overflow_reg;

endmodule
